// File: rtl/tone_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tone_scheduler
// Description : Score sequencer for a simple tone generator. Steps through an
//               external score ROM one note code per beat, mutes the tone for
//               the last GAP ticks of every beat, and lets live piano keys
//               override the score at any time. PLAY/PAUSE/IDLE control via
//               one-cycle play/stop pulses.
//
// Parameters  : TIME      clk ticks per beat
//               GAP       muted ticks at the end of each beat (GAP < TIME)
//               SONG_LEN  number of score steps (2..256)
//
// Ports       : clk          sole clock, rising edge
//               rst          asynchronous active-high reset
//               play         pulse: IDLE->PLAY, PLAY->PAUSE, PAUSE->PLAY
//               stop         pulse: any state -> IDLE (wins over play)
//               loop         level: 1 = wrap score at end, 0 = stop at end
//               key[7:0]     live keys, 1 = pressed, lowest index wins
//               rom_addr     score step index to external ROM
//               rom_data     note code for rom_addr (combinational ROM)
//               half_period  tone-generator toggle count
//               tone_en      1 = tone generator sounds half_period
//               src_key      1 = tone from key, 0 = tone from score
//               state        00 IDLE, 01 PLAY, 10 PAUSE
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tone_scheduler #(
  parameter int TIME     = 12000000,
  parameter int GAP      = 600000,
  parameter int SONG_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        stop,
  input  logic        loop,
  input  logic [7:0]  key,
  output logic [7:0]  rom_addr,
  input  logic [3:0]  rom_data,
  output logic [16:0] half_period,
  output logic        tone_en,
  output logic        src_key,
  output logic [1:0]  state
);

  // Beat counter width; at least one bit even for tiny TIME values.
  localparam int c_cnt_w = (TIME > 2) ? $clog2(TIME) : 1;

  // Last tick of a beat, and the first tick of the muted articulation gap.
  // The gap boundary gets one extra bit so TIME-GAP == TIME (GAP=0) still fits.
  localparam logic [c_cnt_w-1:0] c_last_tick = c_cnt_w'(TIME - 1);
  localparam logic [c_cnt_w:0]   c_gap_start = (c_cnt_w + 1)'(TIME - GAP);
  localparam logic [7:0]         c_last_step = 8'(SONG_LEN - 1);

  // Tone half-periods in clk ticks.
  localparam logic [16:0] c_l3 = 17'd75850;
  localparam logic [16:0] c_l5 = 17'd63776;
  localparam logic [16:0] c_l6 = 17'd56818;
  localparam logic [16:0] c_l7 = 17'd50618;
  localparam logic [16:0] c_m1 = 17'd47774;
  localparam logic [16:0] c_m2 = 17'd42568;
  localparam logic [16:0] c_m3 = 17'd37919;
  localparam logic [16:0] c_m5 = 17'd31888;
  localparam logic [16:0] c_m6 = 17'd28409;
  localparam logic [16:0] c_h1 = 17'd23889;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_beat_cnt;

  logic                 w_key_any;
  logic [16:0]          w_key_note;
  logic [16:0]          w_score_note;
  logic                 w_score_sounding;
  logic                 w_beat_end;

  assign state = r_state;

  //--------------------------------------------------------------------------
  // Live keys: lowest pressed index wins, so scan from the top down and let
  // later (lower) matches overwrite.
  //--------------------------------------------------------------------------
  assign w_key_any = |key;

  always_comb begin
    w_key_note = '0;
    if (key[7]) w_key_note = c_h1;
    if (key[6]) w_key_note = c_m6;
    if (key[5]) w_key_note = c_m5;
    if (key[4]) w_key_note = c_m3;
    if (key[3]) w_key_note = c_m2;
    if (key[2]) w_key_note = c_m1;
    if (key[1]) w_key_note = c_l7;
    if (key[0]) w_key_note = c_l6;
  end

  //--------------------------------------------------------------------------
  // Score note decode. Zero means rest; codes 11..15 are also rests.
  //--------------------------------------------------------------------------
  always_comb begin
    w_score_note = '0;
    case (rom_data)
      4'd1:    w_score_note = c_l3;
      4'd2:    w_score_note = c_l5;
      4'd3:    w_score_note = c_l6;
      4'd4:    w_score_note = c_l7;
      4'd5:    w_score_note = c_m1;
      4'd6:    w_score_note = c_m2;
      4'd7:    w_score_note = c_m3;
      4'd8:    w_score_note = c_m5;
      4'd9:    w_score_note = c_m6;
      4'd10:   w_score_note = c_h1;
      default: w_score_note = '0;
    endcase
  end

  // Score sounds only while playing, on a real note, before the gap opens.
  assign w_score_sounding = (r_state == ST_PLAY) &&
                            (w_score_note != '0) &&
                            ({1'b0, r_beat_cnt} < c_gap_start);

  assign w_beat_end = (r_beat_cnt == c_last_tick);

  //--------------------------------------------------------------------------
  // Sequencer and registered outputs. Outputs are computed from this cycle's
  // state/counters/inputs and appear one clock later.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      rom_addr    <= '0;
      half_period <= '0;
      tone_en     <= 1'b0;
      src_key     <= 1'b0;
    end else begin
      // Tone selection: keys override the score in every state. When nothing
      // sounds, half_period keeps its last value.
      if (w_key_any) begin
        src_key     <= 1'b1;
        tone_en     <= 1'b1;
        half_period <= w_key_note;
      end else begin
        src_key <= 1'b0;
        if (w_score_sounding) begin
          tone_en     <= 1'b1;
          half_period <= w_score_note;
        end else begin
          tone_en <= 1'b0;
        end
      end

      // Transport control; stop beats play when both pulse together.
      if (stop) begin
        r_state    <= ST_IDLE;
        r_beat_cnt <= '0;
        rom_addr   <= '0;
      end else if (play) begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_PLAY;
            r_beat_cnt <= '0;
            rom_addr   <= '0;
          end
          ST_PLAY:  r_state <= ST_PAUSE;
          ST_PAUSE: r_state <= ST_PLAY;   // resume with counters untouched
          default: begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            rom_addr   <= '0;
          end
        endcase
      end else if ((r_state == ST_PLAY) && !w_key_any) begin
        // Beat timing advances only while the score is in control; a held key
        // freezes both the tick count and the score position.
        if (w_beat_end) begin
          r_beat_cnt <= '0;
          if (rom_addr == c_last_step) begin
            rom_addr <= '0;
            if (!loop) begin
              r_state <= ST_IDLE;
            end
          end else begin
            rom_addr <= rom_addr + 8'd1;
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tone_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_tone_scheduler
// Description : Self-checking bench for tone_scheduler with TIME=10, GAP=2,
//               SONG_LEN=4 and score ROM 5,7,0,3. A key-mapping vector table
//               plus directed sequences for playback, end/loop, key freeze,
//               pause/resume and asynchronous reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tone_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [7:0]  key = 8'h00;
  logic [7:0]  rom_addr;
  logic [3:0]  rom_data;
  logic [16:0] half_period;
  logic        tone_en;
  logic        src_key;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_hp = 17'd0;

  always #5 clk = ~clk;

  tone_scheduler #(.TIME(10), .GAP(2), .SONG_LEN(4)) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .loop(loop), .key(key),
    .rom_addr(rom_addr), .rom_data(rom_data), .half_period(half_period),
    .tone_en(tone_en), .src_key(src_key), .state(state)
  );

  // Score ROM: 5 (M_1), 7 (M_3), 0 (rest), 3 (L_6).
  function automatic logic [3:0] rom_code(input int a);
    case (a)
      0: return 4'd5;
      1: return 4'd7;
      2: return 4'd0;
      3: return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [16:0] code_note(input logic [3:0] c);
    case (c)
      4'd3: return 17'd56818;
      4'd5: return 17'd47774;
      4'd7: return 17'd37919;
      default: return 17'd0;
    endcase
  endfunction

  assign rom_data = rom_code(int'(rom_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pulse play from IDLE and check ncyc cycles of playback by formula:
  // after edge k the outputs reflect beat (k-1)/10, tick (k-1)%10.
  task automatic play_beats(input logic lp, input int ncyc);
    int b, c, addr_e, st_e;
    logic te, ended;
    loop = lp;
    play = 1'b1;
    step();
    play = 1'b0;
    check("start_state", 32'(state), 32'd1);
    check("start_addr", 32'(rom_addr), 32'd0);
    check("start_tone", 32'(tone_en), 32'd0);
    for (int k = 1; k <= ncyc; k++) begin
      step();
      b     = ((k - 1) / 10) % 4;
      c     = (k - 1) % 10;
      ended = !lp && (k > 40);
      te    = !ended && (rom_code(b) != 4'd0) && (c < 8);
      if (te) exp_hp = code_note(rom_code(b));
      if (lp) begin
        addr_e = (k / 10) % 4;
        st_e   = 1;
      end else begin
        addr_e = (k >= 40) ? 0 : k / 10;
        st_e   = (k >= 40) ? 0 : 1;
      end
      check($sformatf("pb%0d_k%0d_tone", lp, k), 32'(tone_en), 32'(te));
      check($sformatf("pb%0d_k%0d_hp", lp, k), 32'(half_period), 32'(exp_hp));
      check($sformatf("pb%0d_k%0d_addr", lp, k), 32'(rom_addr), 32'(addr_e));
      check($sformatf("pb%0d_k%0d_state", lp, k), 32'(state), 32'(st_e));
      check($sformatf("pb%0d_k%0d_src", lp, k), 32'(src_key), 32'd0);
    end
  endtask

  typedef struct {
    logic [7:0]  key;
    logic        exp_tone;
    logic        exp_src;
    logic [16:0] exp_hp;
  } kvec_t;

  kvec_t kv [12];

  initial begin
    kv[0]  = '{8'h01, 1'b1, 1'b1, 17'd56818};
    kv[1]  = '{8'h02, 1'b1, 1'b1, 17'd50618};
    kv[2]  = '{8'h04, 1'b1, 1'b1, 17'd47774};
    kv[3]  = '{8'h08, 1'b1, 1'b1, 17'd42568};
    kv[4]  = '{8'h10, 1'b1, 1'b1, 17'd37919};
    kv[5]  = '{8'h20, 1'b1, 1'b1, 17'd31888};
    kv[6]  = '{8'h40, 1'b1, 1'b1, 17'd28409};
    kv[7]  = '{8'h80, 1'b1, 1'b1, 17'd23889};
    kv[8]  = '{8'hC0, 1'b1, 1'b1, 17'd28409};
    kv[9]  = '{8'h14, 1'b1, 1'b1, 17'd47774};
    kv[10] = '{8'hFF, 1'b1, 1'b1, 17'd56818};
    kv[11] = '{8'h00, 1'b0, 1'b0, 17'd56818};  // release: half_period held

    // Reset state
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_hp", 32'(half_period), 32'd0);
    check("rst_tone", 32'(tone_en), 32'd0);
    check("rst_src", 32'(src_key), 32'd0);
    rst = 1'b0;
    steps(2);
    check("idle_tone", 32'(tone_en), 32'd0);

    // Key mapping in IDLE
    for (int i = 0; i < 12; i++) begin
      key = kv[i].key;
      step();
      check($sformatf("key%0d_tone", i), 32'(tone_en), 32'(kv[i].exp_tone));
      check($sformatf("key%0d_src", i), 32'(src_key), 32'(kv[i].exp_src));
      check($sformatf("key%0d_hp", i), 32'(half_period), 32'(kv[i].exp_hp));
      check($sformatf("key%0d_state", i), 32'(state), 32'd0);
      check($sformatf("key%0d_addr", i), 32'(rom_addr), 32'd0);
    end
    exp_hp = 17'd56818;

    // Full song, no loop: ends in IDLE
    play_beats(1'b0, 42);

    // Looping: wraps 3 -> 0 and keeps playing
    play_beats(1'b1, 45);
    stop = 1'b1; step(); stop = 1'b0;
    check("loop_stop_state", 32'(state), 32'd0);
    check("loop_stop_addr", 32'(rom_addr), 32'd0);
    loop = 1'b0;
    step();

    // Key freeze during beat 1 tick 4
    play = 1'b1; step(); play = 1'b0;
    steps(14);
    check("kf_pre_addr", 32'(rom_addr), 32'd1);
    key = 8'b0001_0100;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("kf%0d_hp", i), 32'(half_period), 32'd47774);
      check($sformatf("kf%0d_src", i), 32'(src_key), 32'd1);
      check($sformatf("kf%0d_tone", i), 32'(tone_en), 32'd1);
      check($sformatf("kf%0d_addr", i), 32'(rom_addr), 32'd1);
    end
    key = 8'h00;
    step();  // tick 4 of beat 1 resumes
    check("kf_rel_src", 32'(src_key), 32'd0);
    check("kf_rel_tone", 32'(tone_en), 32'd1);
    check("kf_rel_hp", 32'(half_period), 32'd37919);
    steps(3);  // reflects tick 7
    check("kf_t7_tone", 32'(tone_en), 32'd1);
    step();    // reflects tick 8: gap
    check("kf_t8_tone", 32'(tone_en), 32'd0);
    check("kf_t8_hp", 32'(half_period), 32'd37919);
    check("kf_t8_addr", 32'(rom_addr), 32'd1);
    step();
    check("kf_wrap_addr", 32'(rom_addr), 32'd2);
    stop = 1'b1; step(); stop = 1'b0;
    exp_hp = 17'd37919;

    // Pause at beat 2 tick 3, resume, then stop+play together
    play = 1'b1; step(); play = 1'b0;
    steps(23);
    check("pz_pre_addr", 32'(rom_addr), 32'd2);
    play = 1'b1; step(); play = 1'b0;
    check("pz_state", 32'(state), 32'd2);
    steps(5);
    check("pz_hold_state", 32'(state), 32'd2);
    check("pz_hold_addr", 32'(rom_addr), 32'd2);
    check("pz_hold_tone", 32'(tone_en), 32'd0);
    key = 8'h80; step();
    check("pz_key_tone", 32'(tone_en), 32'd1);
    check("pz_key_hp", 32'(half_period), 32'd23889);
    check("pz_key_src", 32'(src_key), 32'd1);
    key = 8'h00; step();
    check("pz_rel_tone", 32'(tone_en), 32'd0);
    check("pz_rel_hp", 32'(half_period), 32'd23889);
    play = 1'b1; step(); play = 1'b0;
    check("rs_state", 32'(state), 32'd1);
    steps(6);  // ticks 4..9
    check("rs_addr_hold", 32'(rom_addr), 32'd2);
    step();
    check("rs_addr_adv", 32'(rom_addr), 32'd3);
    step();
    check("rs_b3_tone", 32'(tone_en), 32'd1);
    check("rs_b3_hp", 32'(half_period), 32'd56818);
    stop = 1'b1; play = 1'b1; step(); stop = 1'b0; play = 1'b0;
    check("sp_state", 32'(state), 32'd0);
    check("sp_addr", 32'(rom_addr), 32'd0);
    step();
    check("sp_tone", 32'(tone_en), 32'd0);

    // Asynchronous reset mid beat 2
    play = 1'b1; step(); play = 1'b0;
    steps(23);
    check("ar_pre_addr", 32'(rom_addr), 32'd2);
    check("ar_pre_state", 32'(state), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_addr", 32'(rom_addr), 32'd0);
    check("ar_hp", 32'(half_period), 32'd0);
    check("ar_tone", 32'(tone_en), 32'd0);
    check("ar_src", 32'(src_key), 32'd0);
    step();
    rst = 1'b0;
    steps(12);
    check("ar_post_state", 32'(state), 32'd0);
    check("ar_post_addr", 32'(rom_addr), 32'd0);
    check("ar_post_tone", 32'(tone_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 SHALL have parameter TIME, default 12000000, clk ticks per beat (one score step).
REQ-002 SHALL have parameter GAP, default 600000, ticks at end of each beat with tone muted (articulation); GAP < TIME.
REQ-003 SHALL have parameter SONG_LEN, default 64, score steps, 2..256.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port play  input  1  one-cycle pulse: IDLE->PLAY, PLAY->PAUSE, PAUSE->PLAY.
REQ-007 SHALL have port stop  input  1  one-cycle pulse: any state -> IDLE.
REQ-008 SHALL have port loop  input  1  level; 1 = wrap score at end, 0 = stop at end.
REQ-009 SHALL have port key  input  8  live piano keys, level, 1 = pressed.
REQ-010 SHALL have port rom_addr  output  8  score step index to external score ROM.
REQ-011 SHALL have port rom_data  input  4  note code for rom_addr, combinational, valid same cycle.
REQ-012 SHALL have port half_period  output  17  tone-generator toggle count.
REQ-013 SHALL have port tone_en  output  1  1 = tone generator sounds half_period.
REQ-014 SHALL have port src_key  output  1  1 = current tone from key, 0 = from score.
REQ-015 SHALL have port state  output  2  00 IDLE, 01 PLAY, 10 PAUSE.

Function
REQ-016 SHALL map note codes: 0 rest, 1 L_3=75850, 2 L_5=63776, 3 L_6=56818, 4 L_7=50618, 5 M_1=47774, 6 M_2=42568, 7 M_3=37919, 8 M_5=31888, 9 M_6=28409, 10 H_1=23889; codes 11-15 = rest.
REQ-017 SHALL map key[0..7] to L_6, L_7, M_1, M_2, M_3, M_5, M_6, H_1; lowest pressed index wins.
REQ-018 SHALL give keys priority: any key pressed -> src_key=1, tone_en=1, half_period=key note, in every state.
REQ-019 SHALL freeze beat counter and rom_addr while any key pressed in PLAY; resume from same count on release.
REQ-020 SHALL, in PLAY with no key, count beat ticks 0..TIME-1; at TIME-1, count->0 and rom_addr advances.
REQ-021 SHALL drive score tone: tone_en=1 when code non-rest and beat count < TIME-GAP, else 0; half_period = mapped code.
REQ-022 SHALL at rom_addr=SONG_LEN-1 end of beat: loop=1 -> rom_addr=0, stay PLAY; loop=0 -> IDLE, rom_addr=0.
REQ-023 SHALL register all outputs; output reflects inputs/counters of previous cycle (1-cycle latency).
REQ-024 SHALL in PAUSE hold rom_addr and beat count, tone_en=0 unless key pressed.
REQ-025 SHALL in IDLE hold rom_addr=0, beat count=0, tone_en=0 unless key pressed.
REQ-026 SHALL give stop priority over play when both pulse same cycle.
REQ-027 SHALL on IDLE->PLAY start at rom_addr=0, count=0; PAUSE->PLAY continues unchanged.
REQ-028 SHALL hold half_period at last value when tone_en=0.

Reset
REQ-029 SHALL on rst=1 asynchronously set state=IDLE, rom_addr=0, beat count=0, half_period=0, tone_en=0, src_key=0.
REQ-030 SHALL on rst mid-PLAY abort immediately; after release, remain IDLE until play pulse.

Verification (TIME=10, GAP=2, SONG_LEN=4, ROM = 5,7,0,3)
REQ-031 SHALL pass: play pulse, no keys -> rom_addr 0,1,2,3 each 10 cycles; tone_en high 8, low 2 per beat; half_period 47774, 37919, (rest: tone_en 0 whole beat), 56818.
REQ-032 SHALL pass: loop=0, play to end -> after beat 3 state=IDLE, rom_addr=0, tone_en=0; loop=1 -> rom_addr wraps 3->0, state=PLAY.
REQ-033 SHALL pass: key=8'b0001_0100 during PLAY beat 1 count 4 for 5 cycles -> half_period=47774, src_key=1; on release beat 1 resumes at count 4, rom_addr=1.
REQ-034 SHALL pass: play, play at beat 2 count 3 -> PAUSE, tone_en=0, count held; play -> resumes count 3; stop+play same cycle -> IDLE.
REQ-035 SHALL pass: rst asserted mid-beat 2 asynchronously -> all outputs reset before next clk edge; IDLE persists after release.
